// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: sequencer for the ping-pong line buffer (bufer_out_line).
// One bank is filled with the current sensor line while the previously
// completed line is read out of the other bank. The banks swap only when the
// filled line is complete and the reader is idle.
module line_buffer_ctrl #(
  parameter int PIX_IN_ROW = 640,
  parameter int DIV_W      = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             LINE_START,
  input  logic             PIX_STROBE,
  input  logic             OUT_START,
  input  logic             LOW_SPEED,
  input  logic [DIV_W-1:0] SPEED_DIV,
  output logic             BUFER_CHANGE,
  output logic             BUFER_IN_EN,
  output logic             START_WRITE,
  output logic             NUMBER_CHAN,
  output logic             BUFER_OUT_EN,
  output logic             LOW_SPEED_OUT,
  output logic [9:0]       PIX_OUT,
  output logic             LINE_READY,
  output logic             LINE_DONE,
  output logic             OVERRUN,
  output logic             UNDERRUN
);

  localparam int               CNT_W    = 10;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_IN_ROW - 1);

  typedef enum logic [1:0] {W_IDLE, W_ARM, W_FILL, W_DONE} w_state_t;
  typedef enum logic       {R_IDLE, R_SEND}                r_state_t;

  w_state_t         w_state, w_next;
  r_state_t         r_state, r_next;
  logic [CNT_W-1:0] wr_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_lim;

  logic swap;      // completed line handed to the reader this cycle
  logic rd_start;  // read of a waiting line accepted
  logic rd_under;  // read requested with nothing waiting
  logic wr_last;   // strobe of the last pixel of the line
  logic div_tick;  // PIX_OUT advances this cycle
  logic rd_last;   // last pixel's period ends this cycle
  logic overrun;

  assign swap     = (w_state == W_DONE) && (r_state == R_IDLE);
  // LINE_READY is the registered value, so a swap in the same cycle does not
  // make an OUT_START succeed unless a line was already waiting.
  assign rd_start = (r_state == R_IDLE) && OUT_START && LINE_READY;
  assign rd_under = (r_state == R_IDLE) && OUT_START && !LINE_READY;
  assign wr_last  = (w_state == W_FILL) && PIX_STROBE && (wr_cnt == LAST_PIX);
  assign div_lim  = LOW_SPEED_OUT ? SPEED_DIV : '0;
  assign div_tick = (div_cnt == div_lim);
  assign rd_last  = (r_state == R_SEND) && div_tick && (PIX_OUT == LAST_PIX);
  assign overrun  = LINE_START && ((w_state == W_FILL) || ((w_state == W_DONE) && !swap));

  // State registers for the write and read FSMs
  always_ff @(posedge CLK) begin
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    if (!RESET_N) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Next-state logic; a restart request takes priority over the last strobe
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would otherwise infer a latch.
    w_next = w_state;
    r_next = r_state;
    unique case (w_state)
      W_IDLE: if (LINE_START) w_next = W_ARM;
      W_ARM:  w_next = W_FILL;
      W_FILL: begin
        if (LINE_START)   w_next = W_ARM;
        else if (wr_last) w_next = W_DONE;
      end
      W_DONE: if (swap) w_next = LINE_START ? W_ARM : W_IDLE;
      default: w_next = W_IDLE;
    endcase
    unique case (r_state)
      R_IDLE: if (rd_start) r_next = R_SEND;
      R_SEND: if (rd_last)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Moore outputs decoded from the current states
  always_comb begin
    START_WRITE  = (w_state == W_ARM);
    BUFER_IN_EN  = (w_state == W_FILL);
    BUFER_OUT_EN = (r_state == R_SEND);
  end

  // Write counter, channel interleave, bank select and line-ready flag
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wr_cnt       <= '0;
      NUMBER_CHAN  <= 1'b0;
      BUFER_CHANGE <= 1'b0;
      LINE_READY   <= 1'b0;
    end else begin
      // Clearing on entry to W_ARM makes NUMBER_CHAN read 0 while START_WRITE is high,
      // even when a partial line with an odd sample count is abandoned.
      if (w_next == W_ARM) begin
        wr_cnt      <= '0;
        NUMBER_CHAN <= 1'b0;
      end else if ((w_state == W_FILL) && PIX_STROBE) begin
        wr_cnt      <= wr_last ? '0 : wr_cnt + CNT_W'(1);
        NUMBER_CHAN <= ~NUMBER_CHAN;
      end
      if (swap) begin
        BUFER_CHANGE <= ~BUFER_CHANGE;
        LINE_READY   <= 1'b1;
      end else if (rd_last) begin
        LINE_READY   <= 1'b0;
      end
    end
  end

  // Read index, low-speed divider and latched speed mode
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      PIX_OUT       <= '0;
      div_cnt       <= '0;
      LOW_SPEED_OUT <= 1'b0;
    end else if (rd_start) begin
      PIX_OUT       <= '0;
      div_cnt       <= '0;
      LOW_SPEED_OUT <= LOW_SPEED;
    end else if (r_state == R_SEND) begin
      if (div_tick) begin
        div_cnt <= '0;
        PIX_OUT <= rd_last ? '0 : PIX_OUT + CNT_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // One-cycle status pulses, registered one cycle after their cause
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      LINE_DONE <= 1'b0;
      OVERRUN   <= 1'b0;
      UNDERRUN  <= 1'b0;
    end else begin
      LINE_DONE <= rd_last;
      OVERRUN   <= overrun;
      UNDERRUN  <= rd_under;
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: scoreboard bench for line_buffer_ctrl. The driver keeps
// a line-level model (which bank holds a ready line, whether one is waiting)
// and pushes expected reads and status pulses; a negedge monitor pops them.
module tb_line_buffer_ctrl;

  localparam int N     = 640;
  localparam int DIV_W = 4;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             LINE_START = 1'b0, PIX_STROBE = 1'b0, OUT_START = 1'b0, LOW_SPEED = 1'b0;
  logic [DIV_W-1:0] SPEED_DIV = '0;
  logic             BUFER_CHANGE, BUFER_IN_EN, START_WRITE, NUMBER_CHAN, BUFER_OUT_EN;
  logic             LOW_SPEED_OUT, LINE_READY, LINE_DONE, OVERRUN, UNDERRUN;
  logic [9:0]       PIX_OUT;

  line_buffer_ctrl #(.PIX_IN_ROW(N), .DIV_W(DIV_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .LINE_START(LINE_START), .PIX_STROBE(PIX_STROBE),
    .OUT_START(OUT_START), .LOW_SPEED(LOW_SPEED), .SPEED_DIV(SPEED_DIV),
    .BUFER_CHANGE(BUFER_CHANGE), .BUFER_IN_EN(BUFER_IN_EN), .START_WRITE(START_WRITE),
    .NUMBER_CHAN(NUMBER_CHAN), .BUFER_OUT_EN(BUFER_OUT_EN), .LOW_SPEED_OUT(LOW_SPEED_OUT),
    .PIX_OUT(PIX_OUT), .LINE_READY(LINE_READY), .LINE_DONE(LINE_DONE),
    .OVERRUN(OVERRUN), .UNDERRUN(UNDERRUN)
  );

  always #5 CLK = ~CLK;

  // Expected read: bank held during the read, speed mode, cycles per index,
  // total enabled cycles and whether it ends with LINE_DONE.
  typedef struct {
    bit bank;
    bit low;
    int per;
    int len;
    bit done;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      under_q[$];
  int      over_q[$];
  int      n_checks = 0, n_fail = 0;
  int      cyc = 0, reads_done = 0, reads_pushed = 0, stray_done = 0;
  bit      mon_en = 1'b0;
  bit      bank_m = 1'b0, ready_m = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_read(input bit bank, input bit low, input int per, input int len, input bit done);
    rd_exp_t e;
    e.bank = bank; e.low = low; e.per = per; e.len = len; e.done = done;
    rd_q.push_back(e);
    reads_pushed++;
  endtask

  // Monitor: pulses appear two negedges after the driver raised their cause.
  initial begin : monitor
    rd_exp_t cur;
    bit      in_rd = 1'b0;
    int      k = 0, errs = 0, t;
    cur.bank = 1'b0; cur.low = 1'b0; cur.per = 1; cur.len = 0; cur.done = 1'b0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (mon_en) begin
        if (UNDERRUN === 1'b1) begin
          if (under_q.size() == 0) check("unexpected_underrun", 1, 0);
          else begin t = under_q.pop_front(); check("underrun_latency", cyc - t, 2); end
        end
        if (OVERRUN === 1'b1) begin
          if (over_q.size() == 0) check("unexpected_overrun", 1, 0);
          else begin t = over_q.pop_front(); check("overrun_latency", cyc - t, 2); end
        end
        if (in_rd && BUFER_OUT_EN !== 1'b1) begin
          check("read_len", k, cur.len);
          check("read_errs", errs, 0);
          check("line_done", LINE_DONE, cur.done);
          check("pix_out_after", PIX_OUT, 0);
          check("ready_after", LINE_READY, 0);
          in_rd = 1'b0;
          reads_done++;
        end else if (LINE_DONE === 1'b1) begin
          stray_done++;
        end
        if (BUFER_OUT_EN === 1'b1) begin
          if (!in_rd) begin
            if (rd_q.size() == 0) check("unexpected_read", 1, 0);
            else cur = rd_q.pop_front();
            in_rd = 1'b1; k = 0; errs = 0;
          end
          if (PIX_OUT !== 10'(k / cur.per) || BUFER_CHANGE !== cur.bank ||
              LOW_SPEED_OUT !== cur.low || LINE_READY !== 1'b1 || BUFER_IN_EN === 1'b1 && 1'b0)
            errs++;
          k++;
        end
      end
    end
  end

  task automatic line_start(input bit exp_over);
    if (exp_over) over_q.push_back(cyc);
    LINE_START = 1'b1; tick(); LINE_START = 1'b0;
    check("start_write", START_WRITE, 1);
    check("chan_at_arm", NUMBER_CHAN, 0);
    tick();
    check("in_en_fill", BUFER_IN_EN, 1);
    check("start_write_pulse", START_WRITE, 0);
  endtask

  task automatic strobes(input int n, input int gap_max);
    int errs = 0;
    for (int i = 0; i < n; i++) begin
      if (NUMBER_CHAN !== 1'(i & 1) || BUFER_IN_EN !== 1'b1) errs++;
      PIX_STROBE = 1'b1; tick(); PIX_STROBE = 1'b0;
      if (i != n - 1) repeat ($urandom_range(0, gap_max)) tick();
    end
    check("chan_seq", errs, 0);
  endtask

  // Called in the first W_DONE cycle; optionally raises OUT_START / LINE_START there.
  task automatic end_line(input bit reader_idle, input bit os, input bit ls);
    check("in_en_done", BUFER_IN_EN, 0);
    if (os) begin
      LOW_SPEED = 1'b0;
      if (ready_m) push_read(!bank_m, 1'b0, 1, N, 1'b1);
      else         under_q.push_back(cyc);
    end
    OUT_START = os; LINE_START = ls;
    tick();
    OUT_START = 1'b0; LINE_START = 1'b0;
    if (reader_idle) begin bank_m = !bank_m; ready_m = 1'b1; end
    check("bank", BUFER_CHANGE, bank_m);
    check("line_ready", LINE_READY, ready_m);
    if (ls) check("start_write_chain", START_WRITE, 1);
  endtask

  task automatic start_read(input bit low, input int div, input int abort_len);
    int per;
    LOW_SPEED = low; SPEED_DIV = DIV_W'(div);
    per = low ? div + 1 : 1;
    if (ready_m) push_read(bank_m, low, per, (abort_len > 0) ? abort_len : N * per, abort_len == 0);
    else         under_q.push_back(cyc);
    OUT_START = 1'b1; tick(); OUT_START = 1'b0;
  endtask

  task automatic wait_read(input int bound);
    int n = 0;
    while (reads_done < reads_pushed && n < bound) begin tick(); n++; end
    check("read_finished", reads_done, reads_pushed);
    ready_m = 1'b0;
  endtask

  initial begin : driver
    int n;
    // Reset held two cycles with every input active
    RESET_N = 1'b0; PIX_STROBE = 1'b1; LINE_START = 1'b1; OUT_START = 1'b1; LOW_SPEED = 1'b1;
    tick(); tick();
    check("reset_outputs", {BUFER_CHANGE, BUFER_IN_EN, START_WRITE, NUMBER_CHAN, BUFER_OUT_EN,
                            LOW_SPEED_OUT, PIX_OUT, LINE_READY, LINE_DONE, OVERRUN, UNDERRUN}, 0);
    check("reset_known", int'($isunknown({BUFER_CHANGE, BUFER_IN_EN, START_WRITE, NUMBER_CHAN,
                            BUFER_OUT_EN, LOW_SPEED_OUT, PIX_OUT, LINE_READY, LINE_DONE,
                            OVERRUN, UNDERRUN})), 0);
    PIX_STROBE = 1'b0; LINE_START = 1'b0; OUT_START = 1'b0; LOW_SPEED = 1'b0;
    RESET_N = 1'b1;
    tick();
    mon_en = 1'b1;

    // Fill, fast read, then an underrun
    line_start(1'b0); strobes(N, 0); end_line(1'b1, 1'b0, 1'b0);
    start_read(1'b0, $urandom_range(0, 15), 0); wait_read(N + 50);
    start_read(1'b0, 0, 0); repeat (3) tick();

    // Low-speed read, SPEED_DIV=3
    line_start(1'b0); strobes(N, 2); end_line(1'b1, 1'b0, 1'b0);
    start_read(1'b1, 3, 0); wait_read(4 * N + 50);

    // Randomised lines, some restarted mid-line
    for (int i = 0; i < 3; i++) begin
      line_start(1'b0);
      if ($urandom_range(0, 1) == 1) begin strobes(101, 1); line_start(1'b1); end
      strobes(N, $urandom_range(0, 2));
      end_line(1'b1, 1'b0, 1'b0);
      start_read(1'($urandom_range(0, 1)), $urandom_range(0, 4), 0);
      wait_read(5 * N + 50);
    end

    // Second line completes during a slow read: held, then overrun on LINE_START
    line_start(1'b0); strobes(N, 0); end_line(1'b1, 1'b0, 1'b0);
    start_read(1'b1, 3, 0);
    line_start(1'b0); strobes(N, 0); end_line(1'b0, 1'b0, 1'b0);
    over_q.push_back(cyc);
    LINE_START = 1'b1; tick(); LINE_START = 1'b0;
    check("held_no_arm", START_WRITE, 0);
    tick();
    check("held_no_arm2", START_WRITE, 0);
    check("held_bank", BUFER_CHANGE, bank_m);
    wait_read(4 * N + 50);
    tick();
    bank_m = !bank_m; ready_m = 1'b1;
    check("late_swap_bank", BUFER_CHANGE, bank_m);
    check("late_swap_ready", LINE_READY, 1);
    start_read(1'b0, 0, 0); wait_read(N + 50);
    start_read(1'b0, 0, 0); repeat (3) tick();

    // Swap coinciding with OUT_START (line waiting) and with OUT_START+LINE_START (none)
    line_start(1'b0); strobes(N, 0); end_line(1'b1, 1'b0, 1'b0);
    line_start(1'b0); strobes(N, 0); end_line(1'b1, 1'b1, 1'b0);
    wait_read(N + 50);
    line_start(1'b0); strobes(N, 1); end_line(1'b1, 1'b1, 1'b1);
    tick();
    check("chain_fill", BUFER_IN_EN, 1);
    strobes(N, 0); end_line(1'b1, 1'b0, 1'b0);
    start_read(1'b0, 0, 0); wait_read(N + 50);

    // Reset in the middle of a read at PIX_OUT=300
    line_start(1'b0); strobes(N, 0); end_line(1'b1, 1'b0, 1'b0);
    start_read(1'b0, 0, 301);
    n = 0;
    while (PIX_OUT !== 10'd300 && n < 2 * N) begin tick(); n++; end
    check("reach_300", PIX_OUT, 300);
    RESET_N = 1'b0; tick(); RESET_N = 1'b1;
    bank_m = 1'b0; ready_m = 1'b0;
    check("mid_rst_out_en", BUFER_OUT_EN, 0);
    check("mid_rst_pix", PIX_OUT, 0);
    check("mid_rst_bank", BUFER_CHANGE, 0);
    check("mid_rst_ready", LINE_READY, 0);
    check("mid_rst_low", LOW_SPEED_OUT, 0);
    wait_read(20);

    repeat (5) tick();
    check("reads_left", rd_q.size(), 0);
    check("underruns_left", under_q.size(), 0);
    check("overruns_left", over_q.size(), 0);
    check("stray_line_done", stray_done, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
